// File: rtl/flow_pkg.sv
// Shared types and constants for the flowing-LED rate controller.
package flow_pkg;

  localparam int SPEED_W      = 2;
  localparam int NUM_SPEEDS   = 4;
  localparam int BOUNCE_STEPS = 7;

  // Debouncer FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    HELD      = 2'd2,
    CHK_REL   = 2'd3
  } deb_state_t;

  // Terminal count of the period counter for a given speed: (base >> speed) - 1
  function automatic int period_last(input int base, input logic [SPEED_W-1:0] spd);
    return (base >> spd) - 32'sd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one synchronized push-button. Emits a registered one-cycle
// press pulse once the input has held high for DEB_CYCLES cycles; release is
// filtered the same way but produces no pulse.
module btn_debounce
  import flow_pkg::*;
#(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  deb_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          press_r, press_s;

  // Next-state, stability counter and press-pulse decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    press_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (raw) begin
          state_s = CHK_PRESS;
        end else begin
          state_s = IDLE;
        end
      end
      CHK_PRESS: begin
        if (!raw) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = HELD;
          cnt_s   = '0;
          press_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      HELD: begin
        cnt_s = '0;
        if (!raw) begin
          state_s = CHK_REL;
        end else begin
          state_s = HELD;
        end
      end
      CHK_REL: begin
        if (raw) begin
          state_s = HELD;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter and press pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      press_r <= press_s;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/flow_rate_ctrl.sv
// Control-side producer for the flowing-LED shifter: debounced direction
// toggle, four step rates, pause/resume and a one-cycle step pulse.
// Optional macro FLOW_BOUNCE_DIR_EN: dir reverses automatically every
// BOUNCE_STEPS step pulses so the LED bounces end to end.
module flow_rate_ctrl
  import flow_pkg::*;
#(
  parameter int DEB_CYCLES  = 2_000_000,
  parameter int BASE_PERIOD = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_dir,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               pause_sw,
  output logic               dir,
  output logic               clk_bps,
  output logic [SPEED_W-1:0] speed
);

  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(NUM_SPEEDS - 1);

  // Bit order: {pause, down, up, dir}
  logic [3:0] sync1_r, sync2_r;
  logic       dir_press_s, up_press_s, down_press_s, pause_s;

  logic [SPEED_W-1:0] speed_r, speed_nxt_s;
  logic               speed_chg_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s, period_last_s;
  logic               clk_bps_r, bps_nxt_s;
  logic               dir_r, dir_nxt_s;

`ifdef FLOW_BOUNCE_DIR_EN
  localparam logic [2:0] BOUNCE_LAST = 3'(BOUNCE_STEPS - 1);
  logic [2:0] bounce_r, bounce_nxt_s;
`endif

  // Two-flop synchronizer for all raw inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= {pause_sw, btn_down, btn_up, btn_dir};
      sync2_r <= sync1_r;
    end
  end

  assign pause_s = sync2_r[3];

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clk(clk), .rst_n(rst_n), .raw(sync2_r[0]), .press(dir_press_s)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .raw(sync2_r[1]), .press(up_press_s)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst_n(rst_n), .raw(sync2_r[2]), .press(down_press_s)
  );

  // Saturating speed update; simultaneous up and down cancel
  always_comb begin
    speed_nxt_s = speed_r;
    if (up_press_s && !down_press_s) begin
      if (speed_r != SPEED_MAX) begin
        speed_nxt_s = speed_r + 2'd1;
      end else begin
        speed_nxt_s = speed_r;
      end
    end else if (down_press_s && !up_press_s) begin
      if (speed_r != 2'd0) begin
        speed_nxt_s = speed_r - 2'd1;
      end else begin
        speed_nxt_s = speed_r;
      end
    end else begin
      speed_nxt_s = speed_r;
    end
  end

  assign speed_chg_s   = (speed_nxt_s != speed_r);
  assign period_last_s = CNT_W'(period_last(BASE_PERIOD, speed_r));

  // Period counter and step pulse; a speed change restarts the period
  always_comb begin
    cnt_nxt_s = cnt_r;
    bps_nxt_s = 1'b0;
    if (speed_chg_s) begin
      cnt_nxt_s = '0;
    end else if (pause_s) begin
      cnt_nxt_s = cnt_r;
    end else if (cnt_r >= period_last_s) begin
      cnt_nxt_s = '0;
      bps_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Direction toggle from the button (and auto-bounce when enabled)
  always_comb begin
    dir_nxt_s = dir_r;
`ifdef FLOW_BOUNCE_DIR_EN
    bounce_nxt_s = bounce_r;
    if (dir_press_s) begin
      dir_nxt_s    = ~dir_r;
      bounce_nxt_s = 3'd0;
    end else if (clk_bps_r) begin
      if (bounce_r == BOUNCE_LAST) begin
        dir_nxt_s    = ~dir_r;
        bounce_nxt_s = 3'd0;
      end else begin
        bounce_nxt_s = bounce_r + 3'd1;
      end
    end else begin
      bounce_nxt_s = bounce_r;
    end
`else
    if (dir_press_s) begin
      dir_nxt_s = ~dir_r;
    end else begin
      dir_nxt_s = dir_r;
    end
`endif
  end

  // Speed, period, pulse and direction registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed_r   <= 2'd0;
      cnt_r     <= '0;
      clk_bps_r <= 1'b0;
      dir_r     <= 1'b0;
    end else begin
      speed_r   <= speed_nxt_s;
      cnt_r     <= cnt_nxt_s;
      clk_bps_r <= bps_nxt_s;
      dir_r     <= dir_nxt_s;
    end
  end

`ifdef FLOW_BOUNCE_DIR_EN
  // Auto-bounce step counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bounce_r <= 3'd0;
    end else begin
      bounce_r <= bounce_nxt_s;
    end
  end
`endif

  assign dir     = dir_r;
  assign clk_bps = clk_bps_r;
  assign speed   = speed_r;

endmodule

// File: tb/tb_flow_rate_ctrl.sv
// Scoreboard bench for flow_rate_ctrl (DEB_CYCLES=4, BASE_PERIOD=16).
// Stimulus pushes expected tick / speed-change / dir-change edges into
// queues; a forked monitor pops and compares whenever the DUT shows one.
module tb_flow_rate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_dir = 1'b0, btn_up = 1'b0, btn_down = 1'b0, pause_sw = 1'b0;
  logic       dir, clk_bps;
  logic [1:0] speed;

  flow_rate_ctrl #(.DEB_CYCLES(4), .BASE_PERIOD(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .btn_dir(btn_dir), .btn_up(btn_up),
    .btn_down(btn_down), .pause_sw(pause_sw), .dir(dir), .clk_bps(clk_bps),
    .speed(speed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int e; int v;} ev_t;
  int   tick_q[$];
  ev_t  spd_q[$];
  ev_t  dir_q[$];

  int         n_checks = 0;
  int         n_fail = 0;
  int         t0 = 0;
  bit         in_reset = 1'b1;
  logic [7:0] led = 8'h80;
  int         bcnt = 0;
  logic       bdir = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event at edge %0d, expected none", nm, cyc);
  endtask

  task automatic push_tick(input int e);
    tick_q.push_back(e);
`ifdef FLOW_BOUNCE_DIR_EN
    bcnt++;
    if (bcnt == 7) begin
      bdir = ~bdir;
      dir_q.push_back('{e + 1, int'(bdir)});
      bcnt = 0;
    end
`endif
  endtask

  task automatic push_dir(input int e, input logic v);
    bdir = v;
    bcnt = 0;
    dir_q.push_back('{e, int'(v)});
  endtask

  task automatic push_spd(input int e, input int v);
    spd_q.push_back('{e, v});
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    rst_n = 1'b0;
    btn_dir = 1'b0; btn_up = 1'b0; btn_down = 1'b0; pause_sw = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dir", int'(dir), 0);
    check("rst_speed", int'(speed), 0);
    check("rst_bps", int'(clk_bps), 0);
    rst_n = 1'b1;
    in_reset = 1'b0;
    t0 = cyc;
    bcnt = 0;
    bdir = 1'b0;
    led = 8'h80;
  endtask

  task automatic end_phase(input string nm);
    check({nm, "_ticks_left"}, tick_q.size(), 0);
    check({nm, "_speed_left"}, spd_q.size(), 0);
    check({nm, "_dir_left"}, dir_q.size(), 0);
    tick_q.delete(); spd_q.delete(); dir_q.delete();
  endtask

  task automatic monitor();
    logic [1:0] prev_speed = 2'd0;
    logic       prev_dir = 1'b0;
    int         te;
    ev_t        ev;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (clk_bps) begin
          if (tick_q.size() == 0) begin
            unexpected("tick");
          end else begin
            te = tick_q.pop_front();
            check("tick_edge", cyc, te);
          end
          if (dir) led = {led[6:0], led[7]};
          else     led = {led[0], led[7:1]};
        end
        if (speed != prev_speed) begin
          if (spd_q.size() == 0) begin
            unexpected("speed_change");
          end else begin
            ev = spd_q.pop_front();
            check("speed_edge", cyc, ev.e);
            check("speed_val", int'(speed), ev.v);
          end
        end
        if (dir != prev_dir) begin
          if (dir_q.size() == 0) begin
            unexpected("dir_change");
          end else begin
            ev = dir_q.pop_front();
            check("dir_edge", cyc, ev.e);
            check("dir_val", int'(dir), ev.v);
          end
        end
      end
      prev_speed = speed;
      prev_dir = dir;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(negedge clk);

    // A: idle tick spacing, then reset mid-count
    do_reset();
    push_tick(t0 + 16); push_tick(t0 + 32); push_tick(t0 + 48);
    wait_until(t0 + 56);
    end_phase("A1");
    do_reset();
    push_tick(t0 + 16); push_tick(t0 + 32);
    wait_until(t0 + 34);
    end_phase("A2");

    // B: 3-cycle glitch rejected, held press raises speed
    do_reset();
    push_tick(t0 + 16); push_tick(t0 + 32);
    push_spd(t0 + 42, 1);
    push_tick(t0 + 50); push_tick(t0 + 58);
    wait_until(t0 + 2);  btn_up = 1'b1;
    wait_until(t0 + 5);  btn_up = 1'b0;
    wait_until(t0 + 34); btn_up = 1'b1;
    wait_until(t0 + 46); btn_up = 1'b0;
    wait_until(t0 + 60);
    end_phase("B");

    // C: five ups saturate at 3, four downs to 0, up+down together no-op
    do_reset();
    push_spd(t0 + 8, 1);  push_spd(t0 + 24, 2); push_spd(t0 + 40, 3);
    push_spd(t0 + 88, 2); push_spd(t0 + 104, 1); push_spd(t0 + 120, 0);
    push_tick(t0 + 16);
    push_tick(t0 + 28); push_tick(t0 + 32); push_tick(t0 + 36);
    for (int t = 42; t <= 86; t += 2) push_tick(t0 + t);
    push_tick(t0 + 92); push_tick(t0 + 96); push_tick(t0 + 100);
    push_tick(t0 + 112);
    push_tick(t0 + 136); push_tick(t0 + 152); push_tick(t0 + 168); push_tick(t0 + 184);
    for (int k = 0; k < 5; k++) begin
      wait_until(t0 + 16 * k);     btn_up = 1'b1;
      wait_until(t0 + 16 * k + 8); btn_up = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      wait_until(t0 + 80 + 16 * k);  btn_down = 1'b1;
      wait_until(t0 + 88 + 16 * k);  btn_down = 1'b0;
    end
    wait_until(t0 + 160); btn_up = 1'b1; btn_down = 1'b1;
    wait_until(t0 + 168); btn_up = 1'b0; btn_down = 1'b0;
    wait_until(t0 + 186);
    end_phase("C");

    // D: two dir presses toggle 0->1->0, tick spacing untouched
    do_reset();
    push_dir(t0 + 10, 1'b1);
    push_tick(t0 + 16);
    push_dir(t0 + 28, 1'b0);
    push_tick(t0 + 32); push_tick(t0 + 48); push_tick(t0 + 64);
    wait_until(t0 + 2);  btn_dir = 1'b1;
    wait_until(t0 + 10); btn_dir = 1'b0;
    wait_until(t0 + 20); btn_dir = 1'b1;
    wait_until(t0 + 28); btn_dir = 1'b0;
    wait_until(t0 + 66);
    end_phase("D");

    // E: pause at count 10 with a dir press inside; then speed change while paused
    do_reset();
    push_tick(t0 + 16);
    push_dir(t0 + 38, 1'b1);
    push_tick(t0 + 72); push_tick(t0 + 88);
    push_spd(t0 + 102, 1);
    push_tick(t0 + 120); push_tick(t0 + 128);
    wait_until(t0 + 24);  pause_sw = 1'b1;
    wait_until(t0 + 30);  btn_dir = 1'b1;
    wait_until(t0 + 38);  btn_dir = 1'b0;
    wait_until(t0 + 64);  pause_sw = 1'b0;
    wait_until(t0 + 90);  pause_sw = 1'b1;
    wait_until(t0 + 94);  btn_up = 1'b1;
    wait_until(t0 + 102); btn_up = 1'b0;
    wait_until(t0 + 110); pause_sw = 1'b0;
    wait_until(t0 + 130);
    end_phase("E");

    // F: downstream shifter from 8'h80 over eight steps
    do_reset();
    for (int k = 1; k <= 8; k++) push_tick(t0 + 16 * k);
    wait_until(t0 + 130);
    end_phase("F");
`ifdef FLOW_BOUNCE_DIR_EN
    check("led_after_8", int'(led), 8'h02);
`else
    check("led_after_8", int'(led), 8'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
